recovery_rom: RTL and testbench
===============================

# recovery_rom

Read-only instruction memory holding the fixed recovery routine that a core executes after a fault is detected. The routine reloads the register file x1..x31 from a checkpoint area, then returns with `mret`. It sits on the instruction-fetch side of the fault-tolerant core pair and is selected by the recovery logic in place of normal program memory. Reads are synchronous, with one-cycle latency, matching the core's fetch interface.

## Interface
- `ROM_WORDS`, 32: number of defined 32-bit words; indices 0..ROM_WORDS-1.
- `CKPT_OFFSET`, 0: byte offset of the checkpoint area relative to x0. CKPT_OFFSET + 4*31 must be ≤ 2047.
- `clk_i` input 1: clock; all state changes on rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `req_i` input 1: read request; sampled on rising edge.
- `addr_i` input 32: byte address of the requested word.
- `rdata_o` output 32: registered read data.

## Operation
- Word index = `addr_i[31:2]`; `addr_i[1:0]` ignored, no misalignment error.
- Contents for word k, k = 0..30: `lw x(k+1), (CKPT_OFFSET + 4*(k+1))(x0)`.
  - Encoding is imm[11:0]<<20 | 3'b010<<12 | (k+1)<<7 | 7'b0000011, with rs1 = 0.
- Word 31: `mret` = 32'h3020_0073.
- Any index ≥ ROM_WORDS, including nonzero `addr_i[31:7]` at default depth, returns `nop` = 32'h0000_0013.
- With default CKPT_OFFSET, first words are:
  - word0 = 32'h0040_2083
  - word1 = 32'h0080_2103
  - word2 = 32'h00C0_2183
  - word30 = 32'h07C0_2F83
- Contents are constant, computed at elaboration. No write path.

## Timing
- Rising edge with `rst_i`=1: `rdata_o` ← 32'h0. Reset has priority over `req_i`.
- Rising edge with `rst_i`=0, `req_i`=1: `rdata_o` ← ROM[`addr_i` sampled at that edge]. Data is valid from that edge until the next update (one-cycle latency).
- Rising edge with `req_i`=0: `rdata_o` holds its previous value.
- `addr_i` changes between edges have no effect on `rdata_o`; there is no combinational path from inputs to output.
- Back-to-back requests are supported, one new word per cycle, no stall, no ready/valid.
- Before the first reset, `rdata_o` is undefined. After reset, `rdata_o` stays 0 until the first request.

## Structure
- Shared package `recovery_rom_pkg`:
  - Opcode/funct constants: OPC_LOAD = 7'b0000011, F3_LW = 3'b010.
  - Instruction constants: MRET = 32'h3020_0073, NOP = 32'h0000_0013.
  - Function `enc_lw(rd, rs1, imm)` returning 32-bit encoding.
- One combinational sub-module `recovery_rom_table` maps word index to instruction. The top module holds only the output register and request/reset logic.

## Test plan
- Reset, then `req_i`=0 with `addr_i`=4 for several cycles → `rdata_o` = 0 throughout.
- Hold `req_i`=1 and step `addr_i` 0, 4, 8 on successive edges → `rdata_o` = 32'h0040_2083, 32'h0080_2103, 32'h00C0_2183, each one edge after its address.
- Drop `req_i` to 0 after `addr_i`=8, then change `addr_i` to 0 → `rdata_o` stays 32'h00C0_2183.
- Sweep `addr_i` = 0x78, 0x7C, 0x80, 0xFFFF_FFFC with `req_i`=1 → `rdata_o` = 32'h07C0_2F83, 32'h3020_0073, 32'h0000_0013, 32'h0000_0013.
- `addr_i`=0x5 and 0x6 with `req_i`=1 → same data as `addr_i`=4 (32'h0080_2103).
- Assert `rst_i` together with `req_i`=1 mid-stream → `rdata_o` = 0 after that edge. After release, the next request returns the correct word.

Source files
------------

// File: rtl/recovery_rom_pkg.sv
// rtl/recovery_rom_pkg.sv - shared encodings and constants for the recovery routine ROM
package recovery_rom_pkg;

    localparam logic [6:0]  OPC_LOAD = 7'b0000011;
    localparam logic [2:0]  F3_LW    = 3'b010;
    localparam logic [31:0] MRET     = 32'h3020_0073;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    // Index of the word holding mret; every index below it reloads x(k+1).
    localparam int unsigned MRET_IDX = 31;

    function automatic logic [31:0] enc_lw(
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [11:0] imm
    );
        return {imm, rs1, F3_LW, rd, OPC_LOAD};
    endfunction

endpackage

// File: rtl/recovery_rom_table.sv
// rtl/recovery_rom_table.sv - combinational word-index to instruction lookup
module recovery_rom_table
    import recovery_rom_pkg::*;
#(
    parameter int ROM_WORDS   = 32,
    parameter int CKPT_OFFSET = 0
) (
    input  logic [29:0] word_idx_i,
    output logic [31:0] instr_o
);

    localparam logic [29:0] ROM_LIMIT = 30'(ROM_WORDS);
    localparam logic [29:0] LAST_IDX  = 30'(MRET_IDX);
    localparam logic [11:0] CKPT_BASE = 12'(CKPT_OFFSET);

    logic [4:0]  rd;
    logic [11:0] imm;

    always_comb begin
        rd      = word_idx_i[4:0] + 5'd1;
        imm     = CKPT_BASE + {5'b0, rd, 2'b00};
        instr_o = NOP;
        // Anything past the defined depth, or past mret, fetches a harmless nop.
        if ((word_idx_i < ROM_LIMIT) && (word_idx_i <= LAST_IDX)) begin
            if (word_idx_i == LAST_IDX) begin
                instr_o = MRET;
            end else begin
                instr_o = enc_lw(rd, 5'd0, imm);
            end
        end
    end

endmodule

// File: rtl/recovery_rom.sv
// rtl/recovery_rom.sv - registered read port of the recovery routine ROM
module recovery_rom
    import recovery_rom_pkg::*;
#(
    parameter int ROM_WORDS   = 32,
    parameter int CKPT_OFFSET = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    output logic [31:0] rdata_o
);

    logic [31:0] table_data;
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;
    logic        unused_byte_offset;

    // Fetches are word-granular; the byte offset is dropped without any error.
    assign unused_byte_offset = ^addr_i[1:0];

    recovery_rom_table #(
        .ROM_WORDS   (ROM_WORDS),
        .CKPT_OFFSET (CKPT_OFFSET)
    ) u_table (
        .word_idx_i (addr_i[31:2]),
        .instr_o    (table_data)
    );

    always_comb begin
        rdata_d = rdata_q;
        if (req_i) begin
            rdata_d = table_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= 32'h0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_recovery_rom.sv
// tb/tb_recovery_rom.sv - directed and random checks of recovery_rom against a reference model
module tb_recovery_rom;

    localparam int CKPT = 0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] addr_i;
    logic [31:0] rdata_o;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] exp_q;

    recovery_rom #(
        .ROM_WORDS   (32),
        .CKPT_OFFSET (CKPT)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .addr_i  (addr_i),
        .rdata_o (rdata_o)
    );

    always #5 clk_i = ~clk_i;

    // Routine contents built from the instruction-format arithmetic directly.
    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        longint unsigned idx;
        longint unsigned val;
        idx = longint'(addr) / 4;
        if (idx <= 30) begin
            val = ((CKPT + 4 * (idx + 1)) * (2 ** 20)) + (2 * (2 ** 12))
                + ((idx + 1) * (2 ** 7)) + 3;
            return val[31:0];
        end
        if (idx == 31) return 32'h3020_0073;
        return 32'h0000_0013;
    endfunction

    task automatic check(input string tag);
        n_total++;
        assert (rdata_o === exp_q) n_pass++;
        else $error("FAIL %s: rdata_o=%h expected=%h", tag, rdata_o, exp_q);
    endtask

    task automatic cycle(input logic r, input logic q, input logic [31:0] a, input string tag);
        rst_i  = r;
        req_i  = q;
        addr_i = a;
        @(posedge clk_i);
        if (r)      exp_q = 32'h0;
        else if (q) exp_q = ref_word(a);
        #1;
        check(tag);
        // Address wiggle between edges must not reach the output.
        addr_i = ~a;
        #1;
        check({tag, "_hold"});
    endtask

    initial begin
        rst_i  = 1'b1;
        req_i  = 1'b0;
        addr_i = 32'h0;
        exp_q  = 32'h0;

        cycle(1, 0, 32'h0, "reset0");
        cycle(1, 1, 32'h4, "reset_req");
        for (int i = 0; i < 4; i++) cycle(0, 0, 32'h4, "idle_after_reset");

        cycle(0, 1, 32'h0, "word0");
        cycle(0, 1, 32'h4, "word1");
        cycle(0, 1, 32'h8, "word2");
        cycle(0, 0, 32'h0, "hold_word2");
        cycle(0, 0, 32'h0, "hold_word2_b");

        cycle(0, 1, 32'h78,        "word30");
        cycle(0, 1, 32'h7C,        "mret");
        cycle(0, 1, 32'h80,        "past_end");
        cycle(0, 1, 32'hFFFF_FFFC, "top_addr");
        cycle(0, 1, 32'h0000_0100, "high_bit_set");

        cycle(0, 1, 32'h5, "misalign_5");
        cycle(0, 1, 32'h6, "misalign_6");
        cycle(0, 1, 32'h7, "misalign_7");

        cycle(0, 1, 32'h10, "pre_reset");
        cycle(1, 1, 32'h14, "reset_mid");
        cycle(0, 0, 32'h14, "idle_post_reset");
        cycle(0, 1, 32'hC,  "post_reset_word3");

        for (int i = 0; i < 200; i++) begin
            logic        r;
            logic        q;
            logic [31:0] a;
            r = ($urandom_range(0, 15) == 0);
            q = $urandom_range(0, 3) != 0;
            a = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 'h9F));
            cycle(r, q, a, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", n_total);
        $fatal(1, "timeout");
    end

endmodule
